// File: rtl/ham_dec.sv
// Streaming Hamming(7,4) single-error-correcting decoder.
//
// Two-stage pipeline: stage 1 registers the received codeword and its syndrome,
// stage 2 registers the corrected data. Both sides use valid/ready with
// full-throughput backpressure. A saturating counter tracks how many delivered
// words needed a correction.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_cw is valid this cycle
//   in_ready   decoder accepts in_cw this cycle
//   in_cw      received codeword, bit index = Hamming position - 1
//   out_valid  out_data/out_err/out_syn are valid
//   out_ready  downstream accepts the output
//   out_data   corrected data {d3,d2,d1,d0}
//   out_err    nonzero syndrome; one bit was inverted
//   out_syn    syndrome {s4,s2,s1}
//   cnt_clr    synchronous clear of err_cnt (wins over an increment)
//   err_cnt    saturating count of delivered words with out_err=1
module ham_dec #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  // Syndrome {s4,s2,s1}; its value is the Hamming position of a single flipped bit.
  function automatic logic [2:0] syndrome(input logic [6:0] cw);
    syndrome = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction

  logic             s1_valid_q;
  logic [6:0]       s1_cw_q;
  logic [2:0]       s1_syn_q;
  logic             s2_valid_q;
  logic [3:0]       s2_data_q;
  logic             s2_err_q;
  logic [2:0]       s2_syn_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  logic             s1_en;
  logic             s2_en;
  logic [6:0]       flip;
  logic [6:0]       cw_fix;

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;
  assign out_syn   = s2_syn_q;
  assign err_cnt   = err_cnt_q;

  // Invert the bit at position syn (index syn-1); syn==0 leaves the word intact.
  // Two flipped bits produce a wrong but nonzero syndrome and are mis-corrected.
  always_comb begin
    flip = '0;
    if (s1_syn_q != 3'd0) begin
      flip[s1_syn_q - 3'd1] = 1'b1;
    end
    cw_fix = s1_cw_q ^ flip;
  end

  // Stage 1: capture codeword and syndrome. Data fields load on invalid beats too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      s1_cw_q    <= in_cw;
      s1_syn_q   <= syndrome(in_cw);
    end
  end

  // Stage 2: corrected data, drives the outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_syn_q   <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
      s2_err_q   <= |s1_syn_q;
      s2_syn_q   <= s1_syn_q;
    end
  end

  // Count corrected deliveries, holding at all-ones instead of wrapping.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ham_dec.sv
// Self-checking bench for ham_dec: table-driven vectors, an encoder-based
// model for flip/random traffic, a scoreboard queue, and hand-written
// sequences for latency, backpressure, counter and asynchronous reset.
module tb_ham_dec;

  localparam int unsigned CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic [2:0] syn;
    logic       err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_cw = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [3:0]       out_data;
  logic             out_err;
  logic [2:0]       out_syn;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   exp_cnt = 0;
  vec_t sb_q[$];
  vec_t cur;
  vec_t tbl[8];
  logic rnd_done = 1'b0;

  always #5 clk = ~clk;

  ham_dec #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cw     (in_cw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_syn   (out_syn),
    .cnt_clr   (cnt_clr),
    .err_cnt   (err_cnt)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic vec_t mk_flip(input logic [3:0] d, input int k);
    vec_t       v;
    logic [6:0] m;
    m = '0;
    if (k != 0) m[k-1] = 1'b1;
    v.cw   = enc(d) ^ m;
    v.data = d;
    v.syn  = 3'(k);
    v.err  = (k != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_cw    = v.cw;
    cur      = v;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", sb_q.size());
    end
    step();
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("wait_out_valid", 32'(out_valid), 1);
  endtask

  // Monitor and scoreboard: sampled on the falling edge, so a handshake seen
  // here completes on the next rising edge.
  initial begin
    vec_t e;
    int   nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        exp_cnt = 0;
      end else begin
        check("err_cnt_model", 32'(err_cnt), 32'(exp_cnt));
        nxt = exp_cnt;
        if (out_valid && out_ready) begin
          n_out++;
          if (sb_q.size() == 0) begin
            check("spurious_out", 32'(out_valid), 0);
          end else begin
            e = sb_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_syn", 32'(out_syn), 32'(e.syn));
            check("out_err", 32'(out_err), 32'(e.err));
            if (e.err && exp_cnt < CNT_MAX) nxt = exp_cnt + 1;
          end
        end
        if (cnt_clr) nxt = 0;
        if (in_valid && in_ready) sb_q.push_back(cur);
        exp_cnt = nxt;
      end
    end
  end

  initial begin
    int n0;
    tbl[0] = '{7'b1001011, 4'b1000, 3'b000, 1'b0};
    tbl[1] = '{7'b1100110, 4'b1101, 3'b000, 1'b0};
    tbl[2] = '{7'b1011011, 4'b1000, 3'b101, 1'b1};
    tbl[3] = '{7'b1100111, 4'b1101, 3'b001, 1'b1};
    tbl[4] = '{7'b0000000, 4'b0000, 3'b000, 1'b0};
    tbl[5] = '{7'b1111111, 4'b1111, 3'b000, 1'b0};
    tbl[6] = '{7'b1001000, 4'b1001, 3'b011, 1'b1};  // double error, mis-corrected
    tbl[7] = '{7'b1110011, 4'b0110, 3'b111, 1'b1};
    cur = tbl[0];

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_syn", 32'(out_syn), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    @(posedge clk);
    #7 rst = 1'b0;
    step();

    // Two-cycle latency on an empty pipeline
    send(tbl[0]);
    check("lat0_not_yet", 32'(out_valid), 0);
    step();
    check("lat0_valid", 32'(out_valid), 1);
    check("lat0_data", 32'(out_data), 32'(tbl[0].data));
    send(tbl[1]);
    check("lat1_not_yet", 32'(out_valid), 0);
    step();
    check("lat1_valid", 32'(out_valid), 1);
    check("lat1_data", 32'(out_data), 32'(tbl[1].data));
    drain();

    // Table vectors, back to back
    for (int i = 0; i < 8; i++) send(tbl[i]);
    drain();

    // Every single-bit flip of 1100110 (data 1101)
    for (int k = 1; k <= 7; k++) send(mk_flip(4'b1101, k));
    drain();

    // Random single-error traffic under random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(mk_flip(4'($urandom_range(0, 15)), int'($urandom_range(0, 7))));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain();

    // Backpressure: four words, output stalled for three cycles
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i]);
      end
      begin
        wait_out_valid();
        for (int c = 0; c < 3; c++) begin
          check("bp_out_valid", 32'(out_valid), 1);
          check("bp_hold_data", 32'(out_data), 32'(tbl[0].data));
          check("bp_in_ready", 32'(in_ready), 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", 32'(n_out - n0), 4);

    // Counter clear, then saturation
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt_cleared", 32'(err_cnt), 0);
    for (int i = 0; i < 5; i++) send(tbl[2]);
    drain();
    check("cnt_saturated", 32'(err_cnt), 3);

    // Clear coincident with an erroneous delivery
    out_ready = 1'b0;
    send(tbl[3]);
    wait_out_valid();
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_beats_inc", 32'(err_cnt), 0);
    check("clr_word_gone", 32'(out_valid), 0);
    send(tbl[7]);
    drain();
    check("cnt_after_clr", 32'(err_cnt), 1);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    cur       = tbl[0];
    in_cw     = tbl[0].cw;
    in_valid  = 1'b1;
    step();
    step();
    step();
    check("pre_rst_full", 32'(out_valid), 1);
    check("pre_rst_stall", 32'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_err_cnt", 32'(err_cnt), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_out_data", 32'(out_data), 0);
    in_valid = 1'b0;
    step();
    step();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_rst_idle", 32'(out_valid), 0);
    end
    check("post_rst_ready", 32'(in_ready), 1);
    send(tbl[1]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
